// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, in-order ROM requests and a
// 2-entry {pc, instr} queue feeding IF_ID, with redirect and wrong-path drop.
module if_fetch_unit #(
   parameter int unsigned       DATA_W   = 32,
   parameter logic [DATA_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_STEP  = 4,
   parameter logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              locker,
   input  logic              redirect,
   input  logic [DATA_W-1:0] redirectAddr,
   output logic              romReq,
   input  logic              romReady,
   output logic [DATA_W-1:0] romAddr,
   input  logic              romValid,
   input  logic [DATA_W-1:0] romData,
   output logic [DATA_W-1:0] addrOut,
   output logic [DATA_W-1:0] dataOut,
   output logic              valid,
   output logic              misalign
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_DRAIN
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] last_pc_q;
   logic [1:0]        count_q, count_d;
   logic [1:0]        outst_q, outst_d;
   logic [1:0]        drop_q, drop_d;
   logic              q_rd_q, q_wr_q;
   logic              tag_rd_q, tag_wr_q;
   logic              misalign_q;

   entry_t            q_mem   [2];
   logic [DATA_W-1:0] tag_mem [2];
   entry_t            head;

   logic              accept, rsp, discard, push, pop;
   logic [2:0]        in_use;

   // Issue only while the queue plus in-flight requests leave a free slot,
   // so a returning response can never overflow the queue.
   always_comb begin
      in_use = {1'b0, count_q} + {1'b0, outst_q};
      romReq = (state_q == S_FETCH) && !redirect && (in_use < 3'd2);
   end

   assign romAddr = pc_q;
   assign accept  = romReq & romReady;
   assign rsp     = romValid & (outst_q != 2'd0);
   assign discard = rsp & (redirect | (drop_q != 2'd0));
   assign push    = rsp & ~discard;
   assign pop     = locker & (count_q != 2'd0) & ~redirect;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      drop_d  = drop_q;
      outst_d = outst_q + {1'b0, accept} - {1'b0, rsp};

      if (redirect) begin
         // No request is accepted on a redirect cycle, so outst_d is exactly
         // what remains in flight on the wrong path.
         pc_d    = {redirectAddr[DATA_W-1:2], 2'b00};
         count_d = 2'd0;
         drop_d  = outst_d;
         state_d = (outst_d != 2'd0) ? S_DRAIN : S_FETCH;
      end else begin
         if (accept) begin
            pc_d = pc_q + DATA_W'(PC_STEP);
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
         if (discard) begin
            drop_d = drop_q - 2'd1;
         end
         case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_DRAIN: if (drop_d == 2'd0) state_d = S_FETCH;
            default: state_d = state_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         last_pc_q  <= RESET_PC;
         count_q    <= 2'd0;
         outst_q    <= 2'd0;
         drop_q     <= 2'd0;
         q_rd_q     <= 1'b0;
         q_wr_q     <= 1'b0;
         tag_rd_q   <= 1'b0;
         tag_wr_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         last_pc_q  <= addrOut;
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         misalign_q <= redirect & (redirectAddr[1:0] != 2'b00);

         if (redirect) begin
            q_rd_q <= 1'b0;
            q_wr_q <= 1'b0;
         end else begin
            if (push) q_wr_q <= ~q_wr_q;
            if (pop)  q_rd_q <= ~q_rd_q;
         end

         // The tag FIFO is never flushed: discarded responses still retire
         // their tag, keeping it aligned with the ROM's in-order replies.
         if (accept) tag_wr_q <= ~tag_wr_q;
         if (rsp)    tag_rd_q <= ~tag_rd_q;
      end
   end

   // NOTE: the storage arrays have no reset; count and pointers alone decide
   // which slots hold live data, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         q_mem[q_wr_q] <= '{pc: tag_mem[tag_rd_q], instr: romData};
      end
      if (accept) begin
         tag_mem[tag_wr_q] <= pc_q;
      end
   end

   assign head     = q_mem[q_rd_q];
   assign valid    = (count_q != 2'd0);
   assign addrOut  = valid ? head.pc : last_pc_q;
   assign dataOut  = valid ? head.instr : NOP;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table and corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, locker, redirect, romReq, romReady, romValid, valid, misalign;
   logic [31:0] redirectAddr, romAddr, romData, addrOut, dataOut;

   if_fetch_unit #(
      .DATA_W   (32),
      .RESET_PC (RESET_PC),
      .PC_STEP  (4),
      .NOP      (NOP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .locker       (locker),
      .redirect     (redirect),
      .redirectAddr (redirectAddr),
      .romReq       (romReq),
      .romReady     (romReady),
      .romAddr      (romAddr),
      .romValid     (romValid),
      .romData      (romData),
      .addrOut      (addrOut),
      .dataOut      (dataOut),
      .valid        (valid),
      .misalign     (misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        locker;
      logic        redirect;
      logic [31:0] raddr;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_ao;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rom_req_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   rom_req_t    romq[$];
   int          rom_last_due;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          rdy_rand = 1'b0;

   ent_t        mq[$];
   logic [31:0] mtags[$];
   logic [31:0] m_pc, m_last;
   int          m_drop;
   bit          m_boot, m_mis;

   logic        s_req, s_rdy, s_valid, s_mis;
   logic [31:0] s_addr, s_ao, s_do;

   vec_t        vecs[8];

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic vec_t mk(input logic lk, input logic rd, input logic [31:0] ra,
                               input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] eao);
      vec_t v;
      v.locker = lk; v.redirect = rd; v.raddr = ra;
      v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_ao = eao;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      mq.delete();
      mtags.delete();
      m_pc   = RESET_PC;
      m_last = RESET_PC;
      m_drop = 0;
      m_boot = 1'b1;
      m_mis  = 1'b0;
      romq.delete();
      rom_last_due = cyc;
   endtask

   // Holds reset for one edge, checks the reset-state outputs, then releases.
   task automatic do_reset();
      reset = 1'b0; redirect = 1'b0; locker = 1'b0;
      romValid = 1'b0; romReady = 1'b0;
      @(posedge clk); #1;
      check("rst_valid",    32'(valid),    32'd0);
      check("rst_romReq",   32'(romReq),   32'd0);
      check("rst_misalign", 32'(misalign), 32'd0);
      check("rst_addrOut",  addrOut,       RESET_PC);
      check("rst_dataOut",  dataOut,       NOP);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   // One clock: drive ROM side, sample DUT, compare with the model, advance.
   task automatic tick();
      ent_t        e;
      logic [31:0] t, eao, edo;
      bit          ev, ereq;
      int          lat, due;

      if (romq.size() > 0 && romq[0].due <= cyc) begin
         romValid = 1'b1;
         romData  = rom_word(romq[0].addr);
      end else begin
         romValid = 1'b0;
         romData  = $urandom;
      end
      romReady = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      s_req = romReq; s_addr = romAddr; s_rdy = romReady;
      s_valid = valid; s_ao = addrOut; s_do = dataOut; s_mis = misalign;

      ev  = (mq.size() != 0);
      eao = ev ? mq[0].pc : m_last;
      edo = ev ? mq[0].instr : NOP;
      check("valid",    32'(s_valid), 32'(ev));
      check("addrOut",  s_ao, eao);
      check("dataOut",  s_do, edo);
      check("misalign", 32'(s_mis), 32'(m_mis));
      ereq = !m_boot && (m_drop == 0) && !redirect && ((mq.size() + mtags.size()) < 2);
      check("romReq", 32'(s_req), 32'(ereq));
      if (ereq && s_req) check("romAddr", s_addr, m_pc);

      if (locker && mq.size() != 0 && !redirect) void'(mq.pop_front());
      if (romValid && mtags.size() != 0) begin
         t = mtags.pop_front();
         if (!redirect) begin
            if (m_drop > 0) m_drop--;
            else begin
               e.pc = t; e.instr = romData;
               mq.push_back(e);
            end
         end
      end
      if (redirect) begin
         mq.delete();
         m_pc   = {redirectAddr[31:2], 2'b00};
         m_drop = mtags.size();
      end else if (ereq && romReady) begin
         mtags.push_back(m_pc);
         m_pc = m_pc + 32'd4;
      end
      m_mis  = redirect && (redirectAddr[1:0] != 2'b00);
      m_last = eao;
      m_boot = 1'b0;

      if (romValid) void'(romq.pop_front());
      if (s_req && romReady) begin
         lat = int'($urandom_range(lat_min, lat_max));
         due = cyc + lat;
         if (due <= rom_last_due) due = rom_last_due + 1;
         romq.push_back('{addr: s_addr, due: due});
         rom_last_due = due;
      end

      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      bit found;
      int n_acc;

      // Startup with a 1-cycle ROM and locker held high.
      vecs[0] = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0);
      vecs[1] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h0,  1'b0, 32'h0);
      vecs[2] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h4,  1'b0, 32'h0);
      vecs[3] = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h0);
      vecs[4] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h8,  1'b1, 32'h4);
      vecs[5] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'hC,  1'b0, 32'h4);
      vecs[6] = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h8);
      vecs[7] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'hC);

      reset = 1'b0; locker = 1'b0; redirect = 1'b0; redirectAddr = '0;
      romReady = 1'b0; romValid = 1'b0; romData = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      for (int i = 0; i < 8; i++) begin
         locker = vecs[i].locker; redirect = vecs[i].redirect; redirectAddr = vecs[i].raddr;
         tick();
         check("t1_romReq", 32'(s_req), 32'(vecs[i].exp_req));
         if (vecs[i].exp_req) check("t1_romAddr", s_addr, vecs[i].exp_addr);
         check("t1_valid",   32'(s_valid), 32'(vecs[i].exp_valid));
         check("t1_addrOut", s_ao, vecs[i].exp_ao);
         check("t1_dataOut", s_do, vecs[i].exp_valid ? rom_word(vecs[i].exp_ao) : NOP);
      end

      // Stall: exactly two entries buffered, issue stops, then drain in order.
      locker = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("t2_full_valid",  32'(s_valid), 32'd1);
      check("t2_full_noreq",  32'(s_req),   32'd0);
      check("t2_full_head",   s_ao, 32'h10);
      check("t2_full_data",   s_do, rom_word(32'h10));
      locker = 1'b1;
      tick();
      check("t2_head0", s_ao, 32'h10);
      tick();
      check("t2_head1", s_ao, 32'h14);
      check("t2_head1_valid", 32'(s_valid), 32'd1);

      // 3-cycle ROM, two requests in flight, redirect drops both.
      do_reset();
      lat_min = 3; lat_max = 3; locker = 1'b1;
      tick(); tick(); tick();
      check("t3_second_req",  32'(s_req), 32'd1);
      check("t3_second_addr", s_addr, 32'h4);
      redirect = 1'b1; redirectAddr = 32'h100;
      tick();
      redirect = 1'b0;
      tick();
      check("t3_drain_noreq", 32'(s_req), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (s_valid) begin
            found = 1'b1;
            check("t3_first_pc", s_ao, 32'h100);
         end
      end
      check("t3_valid_seen", 32'(found), 32'd1);

      // Misaligned redirect target.
      redirect = 1'b1; redirectAddr = 32'h102;
      tick();
      redirect = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 0) check("t4_mis_pulse", 32'(s_mis), 32'd1);
         if (i == 1) check("t4_mis_clear", 32'(s_mis), 32'd0);
         if (s_req && !found) begin
            found = 1'b1;
            check("t4_fetch_addr", s_addr, 32'h100);
         end
      end
      check("t4_req_seen", 32'(found), 32'd1);

      // PC wrap at the top of the address space.
      lat_min = 1; lat_max = 1;
      redirect = 1'b1; redirectAddr = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_req && s_rdy) begin
            if (n_acc == 0) check("t5_top_addr", s_addr, 32'hFFFF_FFFC);
            else if (n_acc == 1) check("t5_wrap_addr", s_addr, 32'h0000_0000);
            n_acc++;
         end
      end
      check("t5_reqs_seen", 32'(n_acc >= 2), 32'd1);

      // Reset with requests in flight, then fetch restarts at RESET_PC.
      lat_min = 3; lat_max = 3; locker = 1'b0;
      tick(); tick(); tick();
      do_reset();
      lat_min = 1; lat_max = 1; locker = 1'b1;
      tick();
      check("t6_boot_noreq", 32'(s_req), 32'd0);
      tick();
      check("t6_restart_req",  32'(s_req), 32'd1);
      check("t6_restart_addr", s_addr, RESET_PC);

      // Randomized traffic against the model.
      rdy_rand = 1'b1; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         locker   = ($urandom_range(0, 9) < 7);
         redirect = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       redirectAddr = $urandom;
            1:       redirectAddr = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            default: redirectAddr = $urandom & 32'h0000_0FFF;
         endcase
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
